// File: rtl/riscv_types.sv
// Shared RISC-V core types.
//   exe_p_mux_bus_type : control bundle that travels with an execution result
//                        (rd / reg_write / FP_reg_write are read by the hazard unit,
//                        the remaining fields are carried through untouched).
//   FP_N_UNITS, fp_unit_e : number and indices of the multi-cycle FP units.
//   fp_entry_t         : one buffered FP result (data + control bundle).
package riscv_types;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] rm;
        logic [4:0] rd;
        logic       reg_write;
        logic       FP_reg_write;
    } exe_p_mux_bus_type;

    localparam int FP_N_UNITS = 4;

    typedef enum logic [1:0] {
        FU_ADDSUB = 2'd0,
        FU_MUL    = 2'd1,
        FU_DIV    = 2'd2,
        FU_SQRT   = 2'd3
    } fp_unit_e;

    typedef struct packed {
        logic [31:0]       data;
        exe_p_mux_bus_type bus;
    } fp_entry_t;

endpackage

// File: rtl/fp_result_collector_fifo.sv
// fp_result_fifo: single-unit circular result buffer.
//   clk, rst            : clock, synchronous active-high reset
//   push, push_data/bus : write one entry at wr_ptr (caller guarantees !full)
//   pop                 : retire the head entry (caller guarantees !empty)
//   head_data/bus       : entry at rd_ptr
//   full, empty         : occupancy flags from the registered count
//   slot_*              : per-slot occupied flag, stored rd and gated write enables
module fp_result_fifo
    import riscv_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [31:0]             push_data,
    input  exe_p_mux_bus_type       push_bus,
    input  logic                    pop,
    output logic [31:0]             head_data,
    output exe_p_mux_bus_type       head_bus,
    output logic                    full,
    output logic                    empty,
    output logic [DEPTH-1:0]        slot_valid,
    output logic [DEPTH-1:0][4:0]   slot_rd,
    output logic [DEPTH-1:0]        slot_reg_write,
    output logic [DEPTH-1:0]        slot_fp_reg_write
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fp_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{data: push_data, bus: push_bus};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem_q[rd_ptr_q].data;
    assign head_bus  = mem_q[rd_ptr_q].bus;

    // Slot k is occupied when its distance from rd_ptr (mod DEPTH) is below count.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            slot_valid[k]        = {1'b0, PW'(k) - rd_ptr_q} < count_q;
            slot_rd[k]           = mem_q[k].bus.rd;
            slot_reg_write[k]    = slot_valid[k] & mem_q[k].bus.reg_write;
            slot_fp_reg_write[k] = slot_valid[k] & mem_q[k].bus.FP_reg_write;
        end
    end

endmodule

// File: rtl/fp_result_collector.sv
// fp_result_collector: buffers FP unit results and round-robins them onto
// the single FP writeback path.
//   res_valid/data/bus : per-unit result presentation (push when unit_en)
//   unit_en            : per-unit advance enable, low while that unit's FIFO is full
//   wb_valid/ready     : writeback handshake; wb_data/bus/unit describe the grant
//   pend_*             : per-slot rd and occupied-gated write enables for hazards
module fp_result_collector
    import riscv_types::*;
#(
    parameter int N_UNITS = FP_N_UNITS,
    parameter int DEPTH   = 2,
    localparam int UW     = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_UNITS-1:0]                  res_valid,
    input  logic [N_UNITS-1:0][31:0]            res_data,
    input  exe_p_mux_bus_type [N_UNITS-1:0]     res_bus,
    output logic [N_UNITS-1:0]                  unit_en,
    output logic                                wb_valid,
    input  logic                                wb_ready,
    output logic [31:0]                         wb_data,
    output exe_p_mux_bus_type                   wb_bus,
    output logic [UW-1:0]                       wb_unit,
    output logic [N_UNITS*DEPTH-1:0][4:0]       pend_rd,
    output logic [N_UNITS*DEPTH-1:0]            pend_reg_write,
    output logic [N_UNITS*DEPTH-1:0]            pend_FP_reg_write
);
    logic [N_UNITS-1:0]              full, empty, push, pop;
    logic [N_UNITS-1:0][31:0]        head_data;
    exe_p_mux_bus_type [N_UNITS-1:0] head_bus;
    logic [N_UNITS-1:0][DEPTH-1:0]   slot_valid;

    logic [UW-1:0] rr_ptr_q, rr_ptr_d;
    logic [UW-1:0] grant;
    logic          grant_found;
    logic          wb_fire;
    int            idx;

    // Enable depends only on registered occupancy: a full FIFO stalls its unit
    // even in a cycle where it is being popped.
    assign unit_en = ~full;
    assign push    = res_valid & unit_en;
    assign wb_fire = wb_valid & wb_ready;

    for (genvar i = 0; i < N_UNITS; i++) begin : g_fifo
        assign pop[i] = wb_fire && (grant == UW'(i));

        fp_result_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk               (clk),
            .rst               (rst),
            .push              (push[i]),
            .push_data         (res_data[i]),
            .push_bus          (res_bus[i]),
            .pop               (pop[i]),
            .head_data         (head_data[i]),
            .head_bus          (head_bus[i]),
            .full              (full[i]),
            .empty             (empty[i]),
            .slot_valid        (slot_valid[i]),
            .slot_rd           (pend_rd[i*DEPTH +: DEPTH]),
            .slot_reg_write    (pend_reg_write[i*DEPTH +: DEPTH]),
            .slot_fp_reg_write (pend_FP_reg_write[i*DEPTH +: DEPTH])
        );
    end

    // First nonempty FIFO at or after rr_ptr, wrapping modulo N_UNITS.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int o = 0; o < N_UNITS; o++) begin
            idx = (int'(rr_ptr_q) + o) % N_UNITS;
            if (!grant_found && !empty[idx]) begin
                grant_found = 1'b1;
                grant       = UW'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (wb_fire) rr_ptr_d = (grant == UW'(N_UNITS - 1)) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end

    assign wb_valid = grant_found;
    assign wb_data  = grant_found ? head_data[grant] : '0;
    assign wb_bus   = grant_found ? head_bus[grant]  : '0;
    assign wb_unit  = grant_found ? grant            : '0;

    // A unit must hold its result while en is low.
    a_no_push_when_stalled: assert property (
        @(posedge clk) disable iff (rst) (res_valid & ~unit_en) == '0
    );

endmodule

// File: tb/tb_fp_result_collector.sv
module tb_fp_result_collector;
    import riscv_types::*;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [3:0]                    res_valid;
    logic [3:0][31:0]              res_data;
    exe_p_mux_bus_type [3:0]       res_bus;
    logic [3:0]                    unit_en;
    logic                          wb_valid;
    logic                          wb_ready;
    logic [31:0]                   wb_data;
    exe_p_mux_bus_type             wb_bus;
    logic [1:0]                    wb_unit;
    logic [7:0][4:0]               pend_rd;
    logic [7:0]                    pend_reg_write;
    logic [7:0]                    pend_FP_reg_write;

    int checks = 0;
    int failures = 0;

    fp_result_collector #(.N_UNITS(4), .DEPTH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .res_valid         (res_valid),
        .res_data          (res_data),
        .res_bus           (res_bus),
        .unit_en           (unit_en),
        .wb_valid          (wb_valid),
        .wb_ready          (wb_ready),
        .wb_data           (wb_data),
        .wb_bus            (wb_bus),
        .wb_unit           (wb_unit),
        .pend_rd           (pend_rd),
        .pend_reg_write    (pend_reg_write),
        .pend_FP_reg_write (pend_FP_reg_write)
    );

    always #5 clk = ~clk;

    function automatic exe_p_mux_bus_type mk_bus(logic [4:0] rd, logic rw, logic frw);
        exe_p_mux_bus_type b;
        b = '0;
        b.opcode       = 7'h53;
        b.rm           = 3'd1;
        b.rd           = rd;
        b.reg_write    = rw;
        b.FP_reg_write = frw;
        return b;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        res_valid = '0;
        res_data  = '0;
        res_bus   = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        wb_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        wb_ready = 1'b0;
        res_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            res_data[i] = 32'h100 + i;
            res_bus[i]  = mk_bus(5'(i + 8), 1'b1, 1'b1);
        end
        step();
        step();
        clear_inputs();
        checks++;
        if (unit_en !== 4'b0000) begin
            failures++;
            $display("FAIL reset_prefill_full: unit_en=%b want 0000", unit_en);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || wb_data !== 32'h0 || wb_unit !== 2'd0 || wb_bus !== '0) begin
            failures++;
            $display("FAIL reset_wb: valid=%b data=%h unit=%0d bus=%h want 0", wb_valid, wb_data, wb_unit, wb_bus);
        end
        checks++;
        if (unit_en !== 4'b1111) begin
            failures++;
            $display("FAIL reset_unit_en: got %b want 1111", unit_en);
        end
        checks++;
        if (pend_reg_write !== 8'h0 || pend_FP_reg_write !== 8'h0 || pend_rd !== '0) begin
            failures++;
            $display("FAIL reset_pend: rw=%b frw=%b rd=%h want 0", pend_reg_write, pend_FP_reg_write, pend_rd);
        end
    endtask

    task automatic test_single();
        exe_p_mux_bus_type b;
        apply_reset();
        b = mk_bus(5'd5, 1'b0, 1'b1);
        wb_ready = 1'b1;
        res_valid[FU_ADDSUB] = 1'b1;
        res_data[FU_ADDSUB]  = 32'h3F800000;
        res_bus[FU_ADDSUB]   = b;
        step();
        clear_inputs();
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h3F800000 || wb_unit !== 2'd0) begin
            failures++;
            $display("FAIL single_wb: valid=%b data=%h unit=%0d want 1 3f800000 0", wb_valid, wb_data, wb_unit);
        end
        checks++;
        if (wb_bus !== b) begin
            failures++;
            $display("FAIL single_bus: got %h want %h", wb_bus, b);
        end
        checks++;
        if (pend_rd[0] !== 5'd5 || pend_FP_reg_write !== 8'h01 || pend_reg_write !== 8'h00) begin
            failures++;
            $display("FAIL single_pend: rd0=%0d frw=%b rw=%b want 5 00000001 00000000", pend_rd[0], pend_FP_reg_write, pend_reg_write);
        end
        step();
        checks++;
        if (wb_valid !== 1'b0 || pend_FP_reg_write !== 8'h00) begin
            failures++;
            $display("FAIL single_drain: valid=%b frw=%b want 0 00000000", wb_valid, pend_FP_reg_write);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        wb_ready = 1'b1;
        for (int burst = 0; burst < 2; burst++) begin
            res_valid = 4'b1111;
            for (int i = 0; i < 4; i++) begin
                res_data[i] = 32'(i + 1);
                res_bus[i]  = mk_bus(5'(i + 1), 1'b1, 1'b0);
            end
            step();
            clear_inputs();
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (wb_valid !== 1'b1 || wb_unit !== 2'(g) || wb_data !== 32'(g + 1)) begin
                    failures++;
                    $display("FAIL rr_burst%0d_grant%0d: valid=%b unit=%0d data=%h want 1 %0d %h",
                             burst, g, wb_valid, wb_unit, wb_data, g, g + 1);
                end
                step();
            end
            checks++;
            if (wb_valid !== 1'b0) begin
                failures++;
                $display("FAIL rr_burst%0d_empty: valid=%b want 0", burst, wb_valid);
            end
        end
        // Unit 3 alone, then units 0 and 3: rr wraps so unit 0 wins next.
        res_valid[FU_SQRT] = 1'b1;
        res_data[FU_SQRT]  = 32'h33;
        res_bus[FU_SQRT]   = mk_bus(5'd3, 1'b1, 1'b0);
        step();
        checks++;
        if (wb_unit !== 2'd3 || wb_data !== 32'h33) begin
            failures++;
            $display("FAIL rr_u3_only: unit=%0d data=%h want 3 33", wb_unit, wb_data);
        end
        res_valid = 4'b1001;
        res_data[FU_ADDSUB] = 32'h10;
        res_data[FU_SQRT]   = 32'h44;
        step();
        clear_inputs();
        checks++;
        if (wb_unit !== 2'd0 || wb_data !== 32'h10) begin
            failures++;
            $display("FAIL rr_wrap: unit=%0d data=%h want 0 10", wb_unit, wb_data);
        end
        step();
        checks++;
        if (wb_unit !== 2'd3 || wb_data !== 32'h44) begin
            failures++;
            $display("FAIL rr_after_wrap: unit=%0d data=%h want 3 44", wb_unit, wb_data);
        end
        step();
        checks++;
        if (wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_final_empty: valid=%b want 0", wb_valid);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        wb_ready = 1'b0;
        res_valid[FU_MUL] = 1'b1;
        res_data[FU_MUL]  = 32'hA1;
        res_bus[FU_MUL]   = mk_bus(5'd11, 1'b1, 1'b0);
        step();
        checks++;
        if (unit_en[1] !== 1'b1 || wb_data !== 32'hA1) begin
            failures++;
            $display("FAIL bp_first: en1=%b data=%h want 1 a1", unit_en[1], wb_data);
        end
        res_data[FU_MUL] = 32'hA2;
        res_bus[FU_MUL]  = mk_bus(5'd12, 1'b1, 1'b0);
        step();
        clear_inputs();
        checks++;
        if (unit_en[1] !== 1'b0 || wb_data !== 32'hA1 || wb_unit !== 2'd1) begin
            failures++;
            $display("FAIL bp_full: en1=%b data=%h unit=%0d want 0 a1 1", unit_en[1], wb_data, wb_unit);
        end
        // Third result is held by the stalled unit; nothing new may enter.
        step();
        step();
        checks++;
        if (unit_en[1] !== 1'b0 || wb_data !== 32'hA1 || pend_reg_write !== 8'b0000_1100) begin
            failures++;
            $display("FAIL bp_hold: en1=%b data=%h rw=%b want 0 a1 00001100", unit_en[1], wb_data, pend_reg_write);
        end
        checks++;
        if (pend_rd[2] !== 5'd11 || pend_rd[3] !== 5'd12) begin
            failures++;
            $display("FAIL bp_pend_rd: rd2=%0d rd3=%0d want 11 12", pend_rd[2], pend_rd[3]);
        end
        wb_ready = 1'b1;
        #1;
        checks++;
        if (unit_en[1] !== 1'b0) begin
            failures++;
            $display("FAIL bp_en_indep_ready: en1=%b want 0", unit_en[1]);
        end
        step();
        checks++;
        if (unit_en[1] !== 1'b1 || wb_data !== 32'hA2) begin
            failures++;
            $display("FAIL bp_release: en1=%b data=%h want 1 a2", unit_en[1], wb_data);
        end
        res_valid[FU_MUL] = 1'b1;
        res_data[FU_MUL]  = 32'hA3;
        res_bus[FU_MUL]   = mk_bus(5'd13, 1'b1, 1'b0);
        step();
        clear_inputs();
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'hA3) begin
            failures++;
            $display("FAIL bp_third: valid=%b data=%h want 1 a3", wb_valid, wb_data);
        end
        step();
        checks++;
        if (wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: valid=%b want 0", wb_valid);
        end
    endtask

    task automatic test_push_pop_same();
        logic [7:0] exp_rw;
        apply_reset();
        wb_ready = 1'b0;
        res_valid[FU_DIV] = 1'b1;
        res_data[FU_DIV]  = 32'hD000;
        res_bus[FU_DIV]   = mk_bus(5'd20, 1'b1, 1'b0);
        step();
        wb_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            res_data[FU_DIV] = 32'hD000 + 32'(c);
            res_bus[FU_DIV]  = mk_bus(5'(20 + c), 1'b1, 1'b0);
            step();
            exp_rw = 8'b1 << (4 + (c % 2));
            checks++;
            if (wb_data !== 32'hD000 + 32'(c) || wb_unit !== 2'd2 || pend_reg_write !== exp_rw || unit_en !== 4'b1111) begin
                failures++;
                $display("FAIL pushpop_c%0d: data=%h unit=%0d rw=%b en=%b want %h 2 %b 1111",
                         c, wb_data, wb_unit, pend_reg_write, unit_en, 32'hD000 + 32'(c), exp_rw);
            end
        end
        clear_inputs();
        step();
        checks++;
        if (wb_valid !== 1'b0 || pend_reg_write !== 8'h0) begin
            failures++;
            $display("FAIL pushpop_drain: valid=%b rw=%b want 0 0", wb_valid, pend_reg_write);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        wb_ready = 1'b0;
        res_valid = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            res_data[i] = 32'h700 + i;
            res_bus[i]  = mk_bus(5'(i + 1), 1'b1, 1'b1);
        end
        step();
        clear_inputs();
        checks++;
        if (pend_reg_write !== 8'b0001_0101 || wb_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: rw=%b valid=%b want 00010101 1", pend_reg_write, wb_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || pend_reg_write !== 8'h0 || pend_FP_reg_write !== 8'h0 || pend_rd !== '0) begin
            failures++;
            $display("FAIL midrst_clear: valid=%b rw=%b frw=%b rd=%h want 0", wb_valid, pend_reg_write, pend_FP_reg_write, pend_rd);
        end
        wb_ready = 1'b1;
        res_valid[FU_MUL] = 1'b1;
        res_data[FU_MUL]  = 32'h55;
        res_bus[FU_MUL]   = mk_bus(5'd9, 1'b1, 1'b1);
        step();
        clear_inputs();
        checks++;
        if (wb_valid !== 1'b1 || wb_unit !== 2'd1 || wb_data !== 32'h55 || pend_FP_reg_write !== 8'b0000_0100) begin
            failures++;
            $display("FAIL midrst_after: valid=%b unit=%0d data=%h frw=%b want 1 1 55 00000100",
                     wb_valid, wb_unit, wb_data, pend_FP_reg_write);
        end
        step();
        checks++;
        if (wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_drain: valid=%b want 0", wb_valid);
        end
    endtask

    initial begin
        clear_inputs();
        wb_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_push_pop_same();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
